ifet_queue: RTL and testbench

Parametrised instruction fetch unit with a decoupling fetch queue. Sits between the instruction cache, the branch predictor and the issue stage. Keeps one cache request in flight, predecodes each returned word to pick the next PC, and buffers fetched instructions in a QDEPTH-entry circular queue so that issue back-pressure does not stall the fetch FSM. A misprediction redirect flushes the queue and drops any stale cache response.

---
 rtl/ifet_queue_if.sv | 36 +++
 rtl/ifet_queue.sv | 161 ++++++++++++++++
 tb/tb_ifet_queue.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifet_queue_if.sv
// Fetch-unit bus: I-cache request/response, branch-predictor lookup,
// issue-side queue head and ROB redirect.
interface ifet_queue_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ILEN   = 32,
    parameter int unsigned QDEPTH = 4
);
    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    logic            oIC_Req;
    logic [XLEN-1:0] oIC_Pc;
    logic            iIC_Ack;
    logic [ILEN-1:0] iIC_Ins;
    logic [XLEN-1:0] oBP_Pc;
    logic            iBP_Taken;
    logic [XLEN-1:0] iBP_Pjt;
    logic            oIS_Valid;
    logic            iIS_Ready;
    logic [ILEN-1:0] oIS_Ins;
    logic            oIS_Bj;
    logic [XLEN-1:0] oIS_Pc;
    logic [XLEN-1:0] oIS_Pjt;
    logic            iROB_Mp;
    logic [XLEN-1:0] iROB_Rpc;
    logic [CW-1:0]   oQ_Cnt;

    modport master (
        output oIC_Req, oIC_Pc, oBP_Pc, oIS_Valid, oIS_Ins, oIS_Bj, oIS_Pc, oIS_Pjt, oQ_Cnt,
        input  iIC_Ack, iIC_Ins, iBP_Taken, iBP_Pjt, iIS_Ready, iROB_Mp, iROB_Rpc
    );

    modport slave (
        input  oIC_Req, oIC_Pc, oBP_Pc, oIS_Valid, oIS_Ins, oIS_Bj, oIS_Pc, oIS_Pjt, oQ_Cnt,
        output iIC_Ack, iIC_Ins, iBP_Taken, iBP_Pjt, iIS_Ready, iROB_Mp, iROB_Rpc
    );
endinterface

// File: rtl/ifet_queue.sv
// Instruction fetch FSM with predecode and a circular fetch queue.
// Optional IFET_JAL_PREDECODE_EN: redirect JAL in fetch instead of via the ROB.
module ifet_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    ifet_queue_if.master bus
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ic_pc_q, ic_pc_d;
    logic            req_q, req_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [ILEN-1:0] ins_mem_q [QDEPTH];
    logic            bj_mem_q  [QDEPTH];
    logic [XLEN-1:0] pc_mem_q  [QDEPTH];
    logic [XLEN-1:0] pjt_mem_q [QDEPTH];

    logic            enq, deq, room, bj_d;
    logic [CW-1:0]   cnt_next;
    logic [XLEN-1:0] pc_plus4, next_pc;

`ifdef IFET_JAL_PREDECODE_EN
    logic [XLEN-1:0] jal_imm;
    assign jal_imm = XLEN'($signed({bus.iIC_Ins[31], bus.iIC_Ins[19:12], bus.iIC_Ins[20],
                                    bus.iIC_Ins[30:21], 1'b0}));
`endif

    // Predecode the returning word into bj flag and next fetch PC
    always_comb begin
        pc_plus4 = pc_q + XLEN'(4);
        bj_d     = 1'b0;
        next_pc  = pc_plus4;
        case (bus.iIC_Ins[6:0])
            OP_BRANCH: begin
                bj_d    = 1'b1;
                next_pc = bus.iBP_Taken ? bus.iBP_Pjt : pc_plus4;
            end
`ifdef IFET_JAL_PREDECODE_EN
            OP_JAL:  next_pc = pc_q + jal_imm;
`else
            OP_JAL:  bj_d = 1'b1;
`endif
            OP_JALR: bj_d = 1'b1;
            default: ;
        endcase
    end

    // Handshakes; a flush cancels both the ack and the dequeue of its cycle
    always_comb begin
        enq      = (state_q == S_WAIT) && bus.iIC_Ack && !bus.iROB_Mp;
        deq      = (cnt_q != '0) && bus.iIS_Ready && !bus.iROB_Mp;
        cnt_next = cnt_q + CW'(enq) - CW'(deq);
        room     = cnt_next < CW'(QDEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.iROB_Mp) begin
            // An ack landing with the flush retires the outstanding request
            case (state_q)
                S_WAIT, S_DROP: state_d = bus.iIC_Ack ? S_IDLE : S_DROP;
                default:        state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE:  if (room) state_d = S_WAIT;
                S_WAIT:  if (bus.iIC_Ack) state_d = room ? S_WAIT : S_IDLE;
                S_DROP:  if (bus.iIC_Ack) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_d    = pc_q;
        ic_pc_d = ic_pc_q;
        req_d   = 1'b0;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_next;
        if (bus.iROB_Mp) begin
            pc_d   = bus.iROB_Rpc;
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (enq) begin
                pc_d   = next_pc;
                tail_d = tail_q + PW'(1);
            end
            if (deq) head_d = head_q + PW'(1);
            if (state_q == S_IDLE && room) begin
                req_d   = 1'b1;
                ic_pc_d = pc_q;
            end
            if (enq && room) begin
                req_d   = 1'b1;
                ic_pc_d = next_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            ic_pc_q <= RESET_PC;
            req_q   <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            ic_pc_q <= ic_pc_d;
            req_q   <= req_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    // Queue storage needs no reset; validity is tracked by cnt_q
    always_ff @(posedge clk) begin
        if (enq) begin
            ins_mem_q[tail_q] <= bus.iIC_Ins;
            bj_mem_q[tail_q]  <= bj_d;
            pc_mem_q[tail_q]  <= pc_q;
            pjt_mem_q[tail_q] <= next_pc;
        end
    end

    assign bus.oIC_Req   = req_q;
    assign bus.oIC_Pc    = ic_pc_q;
    assign bus.oBP_Pc    = pc_q;
    assign bus.oIS_Valid = (cnt_q != '0);
    assign bus.oIS_Ins   = ins_mem_q[head_q];
    assign bus.oIS_Bj    = bj_mem_q[head_q];
    assign bus.oIS_Pc    = pc_mem_q[head_q];
    assign bus.oIS_Pjt   = pjt_mem_q[head_q];
    assign bus.oQ_Cnt    = cnt_q;
endmodule

// File: tb/tb_ifet_queue.sv
// Directed bench for ifet_queue: table-driven L=1 stream plus hand sequences
// for full queue, branch/JAL predecode and flush corner cases.
module tb_ifet_queue;
    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam int unsigned QDEPTH = 4;
    localparam logic [31:0] ADDI = 32'h0010_0093;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   pend = -1;
    int   reqs = 0;
    int   acks = 0;

    always #5 clk = ~clk;

    ifet_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .QDEPTH(QDEPTH)) bus ();
    ifet_queue #(.XLEN(XLEN), .ILEN(ILEN), .QDEPTH(QDEPTH), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic        ack;
        logic        ready;
        logic        req;
        logic [31:0] icpc;
        logic        valid;
        logic [31:0] ispc;
        logic [31:0] pjt;
        logic [31:0] cnt;
        logic [31:0] bp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.iIC_Ack   = 1'b0;
        bus.iIC_Ins   = ADDI;
        bus.iBP_Taken = 1'b0;
        bus.iBP_Pjt   = '0;
        bus.iIS_Ready = 1'b0;
        bus.iROB_Mp   = 1'b0;
        bus.iROB_Rpc  = '0;
        pend = -1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Cache model: answers each request L cycles later with a fixed word
    task automatic run_cycles(input int n, input int lat);
        reqs = 0;
        acks = 0;
        for (int i = 0; i < n; i++) begin
            if (pend > 0) pend--;
            bus.iIC_Ack = (pend == 0);
            if (pend == 0) begin
                acks++;
                pend = -1;
            end
            if (bus.oIC_Req) begin
                reqs++;
                pend = lat;
            end
            step();
        end
        bus.iIC_Ack = 1'b0;
    endtask

    task automatic flush(input logic [31:0] rpc);
        bus.iROB_Mp  = 1'b1;
        bus.iROB_Rpc = rpc;
        step();
        bus.iROB_Mp = 1'b0;
    endtask

    // Fetch one word with L=1 into an empty queue and check its entry and the follow-up request
    task automatic fetch_check(input string name, input logic [31:0] ins, input logic taken,
                               input logic [31:0] bpjt, input logic [31:0] exp_pc,
                               input logic exp_bj, input logic [31:0] exp_pjt);
        int n = 0;
        while (!bus.oIC_Req && n < 10) begin
            step();
            n++;
        end
        chk({name, "_req"}, 32'(bus.oIC_Req), 32'd1);
        chk({name, "_icpc"}, bus.oIC_Pc, exp_pc);
        step();
        bus.iIC_Ack   = 1'b1;
        bus.iIC_Ins   = ins;
        bus.iBP_Taken = taken;
        bus.iBP_Pjt   = bpjt;
        step();
        bus.iIC_Ack   = 1'b0;
        bus.iBP_Taken = 1'b0;
        chk({name, "_valid"}, 32'(bus.oIS_Valid), 32'd1);
        chk({name, "_ispc"}, bus.oIS_Pc, exp_pc);
        chk({name, "_bj"}, 32'(bus.oIS_Bj), 32'(exp_bj));
        chk({name, "_pjt"}, bus.oIS_Pjt, exp_pjt);
        chk({name, "_nextreq"}, 32'(bus.oIC_Req), 32'd1);
        chk({name, "_nextpc"}, bus.oIC_Pc, exp_pjt);
    endtask

    initial begin
        // L=1 addi stream, issue always ready: one instruction every 2 cycles
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0,  32'd0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0, 32'h0,  32'd0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0,  32'd0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b1, 32'h0, 32'h4,  32'd1, 32'h4};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0,  32'd0, 32'h4};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h4, 32'h8,  32'd1, 32'h8};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0,  32'd0, 32'h8};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h8, 32'hC,  32'd1, 32'hC};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0,  32'd0, 32'hC};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC, 32'h10, 32'd1, 32'h10};

        do_reset();
        for (int r = 0; r < 10; r++) begin
            bus.iIC_Ack   = vecs[r].ack;
            bus.iIS_Ready = vecs[r].ready;
            #1;
            chk($sformatf("row%0d_req", r), 32'(bus.oIC_Req), 32'(vecs[r].req));
            if (vecs[r].req) chk($sformatf("row%0d_icpc", r), bus.oIC_Pc, vecs[r].icpc);
            chk($sformatf("row%0d_valid", r), 32'(bus.oIS_Valid), 32'(vecs[r].valid));
            if (vecs[r].valid) begin
                chk($sformatf("row%0d_ispc", r), bus.oIS_Pc, vecs[r].ispc);
                chk($sformatf("row%0d_pjt", r), bus.oIS_Pjt, vecs[r].pjt);
                chk($sformatf("row%0d_bj", r), 32'(bus.oIS_Bj), 32'd0);
                chk($sformatf("row%0d_ins", r), bus.oIS_Ins, ADDI);
            end
            chk($sformatf("row%0d_cnt", r), 32'(bus.oQ_Cnt), vecs[r].cnt);
            chk($sformatf("row%0d_bppc", r), bus.oBP_Pc, vecs[r].bp);
            step();
        end
        bus.iIC_Ack = 1'b0;

        // Full queue: exactly QDEPTH acks, then requests stop
        do_reset();
        run_cycles(30, 1);
        chk("full_reqs", 32'(reqs), 32'd4);
        chk("full_acks", 32'(acks), 32'd4);
        chk("full_cnt", 32'(bus.oQ_Cnt), 32'd4);
        run_cycles(5, 1);
        chk("full_noreq", 32'(reqs), 32'd0);
        bus.iIS_Ready = 1'b1;
        step();
        bus.iIS_Ready = 1'b0;
        chk("free_req", 32'(bus.oIC_Req), 32'd1);
        chk("free_icpc", bus.oIC_Pc, 32'h10);
        chk("free_cnt", 32'(bus.oQ_Cnt), 32'd3);
        chk("free_head", bus.oIS_Pc, 32'h4);
        step();
        bus.iIC_Ack   = 1'b1;
        bus.iIS_Ready = 1'b1;
        step();
        bus.iIC_Ack   = 1'b0;
        bus.iIS_Ready = 1'b0;
        chk("enqdeq_cnt", 32'(bus.oQ_Cnt), 32'd3);
        chk("enqdeq_head", bus.oIS_Pc, 32'h8);
        chk("enqdeq_req", 32'(bus.oIC_Req), 32'd1);
        chk("enqdeq_icpc", bus.oIC_Pc, 32'h14);

        // Branch predecode, taken and not taken
        do_reset();
        flush(32'h10);
        fetch_check("br_taken", 32'h0000_0063, 1'b1, 32'h40, 32'h10, 1'b1, 32'h40);
        do_reset();
        flush(32'h10);
        fetch_check("br_ntaken", 32'h0000_0063, 1'b0, 32'h40, 32'h10, 1'b1, 32'h14);

        // JAL with imm field 0x10, and JALR
        do_reset();
        flush(32'h20);
`ifdef IFET_JAL_PREDECODE_EN
        fetch_check("jal", 32'h0100_006F, 1'b0, 32'h0, 32'h20, 1'b0, 32'h30);
`else
        fetch_check("jal", 32'h0100_006F, 1'b0, 32'h0, 32'h20, 1'b1, 32'h24);
`endif
        do_reset();
        flush(32'h24);
        fetch_check("jalr", 32'h0000_8067, 1'b0, 32'h0, 32'h24, 1'b1, 32'h28);

        // Flush with a request outstanding at L=5: stale ack dropped
        do_reset();
        step();
        chk("drop_req0", 32'(bus.oIC_Req), 32'd1);
        step();
        flush(32'h80);
        chk("drop_bppc", bus.oBP_Pc, 32'h80);
        for (int c = 3; c < 8; c++) begin
            bus.iIC_Ack = (c == 6);
            #1;
            chk($sformatf("drop_valid_c%0d", c), 32'(bus.oIS_Valid), 32'd0);
            chk($sformatf("drop_req_c%0d", c), 32'(bus.oIC_Req), 32'd0);
            step();
        end
        bus.iIC_Ack = 1'b0;
        chk("drop_newreq", 32'(bus.oIC_Req), 32'd1);
        chk("drop_newpc", bus.oIC_Pc, 32'h80);
        chk("drop_cnt", 32'(bus.oQ_Cnt), 32'd0);

        // Flush coincident with ack and dequeue, 3 entries queued
        do_reset();
        run_cycles(7, 1);
        chk("co_req", 32'(bus.oIC_Req), 32'd1);
        chk("co_icpc", bus.oIC_Pc, 32'hC);
        chk("co_cnt3", 32'(bus.oQ_Cnt), 32'd3);
        step();
        bus.iIC_Ack   = 1'b1;
        bus.iIS_Ready = 1'b1;
        flush(32'h200);
        bus.iIC_Ack   = 1'b0;
        bus.iIS_Ready = 1'b0;
        chk("co_valid", 32'(bus.oIS_Valid), 32'd0);
        chk("co_cnt0", 32'(bus.oQ_Cnt), 32'd0);
        chk("co_noreq", 32'(bus.oIC_Req), 32'd0);
        step();
        chk("co_newreq", 32'(bus.oIC_Req), 32'd1);
        chk("co_newpc", bus.oIC_Pc, 32'h200);
        chk("co_cnt_after", 32'(bus.oQ_Cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
